// File: rtl/uart_tx_if.sv
// Fifo read-port bundle between a first-word-fall-through TX fifo and uart_tx.
// Latency: none, plain wires. Backpressure: the transmitter pops only when it can start a frame.
// Ports: i_fifo_data/i_fifo_empty flow fifo->uart, o_fifo_rd_en flows uart->fifo.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_fifo_data;
  logic                 i_fifo_empty;
  logic                 o_fifo_rd_en;

  // fifo side: presents the head word, receives the pop strobe
  modport master (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_rd_en
  );

  // transmitter side: reads the head word, issues the pop strobe
  modport slave (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_rd_en
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from a FWFT fifo, sends start/data(LSB first)/parity/stop.
// Latency: o_tx falls one cycle after the load condition is first seen in IDLE; all outputs registered.
// Backpressure: pops only at a frame boundary when i_en=1 and the fifo is non-empty; back-to-back frames have no gap.
// Ports: i_clk, i_rst (async active-high), i_en, fifo (uart_tx_if.slave), o_tx, o_busy, o_done.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_en,
  uart_tx_if.slave fifo,
  output logic     o_tx,
  output logic     o_busy,
  output logic     o_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 rd_en_q, rd_en_d;
  logic                 done_q, done_d;

  logic bit_end;
  logic last_stop;
  logic load;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_stop = (state_q == S_STOP) && (stop_q == STOP_LAST);
  // A new word may be taken from IDLE, or on the very last cycle of the final stop bit
  // so that consecutive frames abut with no idle gap.
  assign load      = i_en && !fifo.i_fifo_empty &&
                     ((state_q == S_IDLE) || (last_stop && bit_end));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    if (load) begin
      state_d = S_START;
      shift_d = fifo.i_fifo_data;
      // Parity is fixed at load time since the shifter is consumed during DATA.
      par_d   = (PARITY == 1) ? ~(^fifo.i_fifo_data) : (^fifo.i_fifo_data);
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      rd_en_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            tx_d    = shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (PARITY != 0) begin
                state_d = S_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
                stop_d  = 1'b0;
              end
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end
        end
        S_STOP: begin
          // done is registered, so it is raised one cycle ahead to land on the final cycle.
          if (last_stop && (baud_q == BAUD_PRE)) begin
            done_d = 1'b1;
          end
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign o_tx              = tx_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign fifo.o_fifo_rd_en = rd_en_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit, each fed by a FWFT fifo model.
// Stimulus pushes fifo words and the expected frame (data, parity bit, start cycle) into a per-instance queue;
// a per-instance monitor captures every frame cycle by cycle and compares it against the popped expectation.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int P_PAR  [4] = '{0, 2, 1, 0};
  localparam int P_STOP [4] = '{1, 1, 1, 2};

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en  = 4'b0000;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] rd;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int PAR   = P_PAR[g];
    localparam int STOP  = P_STOP[g];
    localparam int FRAME = (1 + 8 + ((PAR != 0) ? 1 : 0) + STOP) * CPB;

    uart_tx_if #(.DATA_BITS(8)) fif ();
    logic [7:0] fq [$];
    exp_t       exp_q [$];

    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY      (PAR),
      .STOP_BITS   (STOP)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (en[g]),
      .fifo  (fif),
      .o_tx  (tx[g]),
      .o_busy(busy[g]),
      .o_done(done[g])
    );

    assign rd[g] = fif.o_fifo_rd_en;

    // FWFT fifo model: pop mid rd_en cycle, then refresh the head word before the next edge.
    always @(negedge clk) begin
      if (rd[g] === 1'b1 && fq.size() != 0) fq.delete(0);
      #1;
      fif.i_fifo_empty = (fq.size() == 0);
      fif.i_fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    end

    initial begin : mon
      logic [63:0] ln, bz, dn, rv, w, got, ones;
      logic        ab;
      int          st;
      exp_t        e;
      ones = (64'd1 << FRAME) - 64'd1;
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && tx[g] === 1'b0) begin
          st = cyc;
          ab = 1'b0;
          ln = '0; bz = '0; dn = '0; rv = '0;
          for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            if (rst !== 1'b0) begin
              ab = 1'b1;
              break;
            end
            ln[k] = tx[g];
            bz[k] = busy[g];
            dn[k] = done[g];
            rv[k] = rd[g];
          end
          if (!ab) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL u%0d_spurious_frame start=%0d expected no frame", g, st);
            end else begin
              e = exp_q.pop_front();
              w = ones;
              for (int j = 0; j < CPB; j++) w[j] = 1'b0;
              for (int i = 0; i < 8; i++)
                for (int j = 0; j < CPB; j++) w[CPB*(1+i)+j] = e.data[i];
              if (PAR != 0)
                for (int j = 0; j < CPB; j++) w[CPB*9+j] = e.par;
              got = '0;
              for (int i = 0; i < 8; i++) got[i] = ln[CPB*(1+i)+CPB/2];
              check($sformatf("u%0d_start_cycle", g), 64'(st), 64'(e.start));
              check($sformatf("u%0d_data", g), got, 64'(e.data));
              check($sformatf("u%0d_wave", g), ln, w);
              check($sformatf("u%0d_busy", g), bz, ones);
              check($sformatf("u%0d_done", g), dn, 64'd1 << (FRAME - 1));
              check($sformatf("u%0d_rd_en", g), rv, 64'd1);
            end
          end
        end
      end
    end
  end

  task automatic push(input int g, input logic [7:0] d);
    case (g)
      0: gen_dut[0].fq.push_back(d);
      1: gen_dut[1].fq.push_back(d);
      2: gen_dut[2].fq.push_back(d);
      default: gen_dut[3].fq.push_back(d);
    endcase
  endtask

  task automatic expect_frame(input int g, input logic [7:0] d, input logic p, input int s);
    exp_t e;
    e.data  = d;
    e.par   = p;
    e.start = s;
    case (g)
      0: gen_dut[0].exp_q.push_back(e);
      1: gen_dut[1].exp_q.push_back(e);
      2: gen_dut[2].exp_q.push_back(e);
      default: gen_dut[3].exp_q.push_back(e);
    endcase
  endtask

  function automatic bit drained();
    return gen_dut[0].exp_q.size() == 0 && gen_dut[1].exp_q.size() == 0 &&
           gen_dut[2].exp_q.size() == 0 && gen_dut[3].exp_q.size() == 0 &&
           busy === 4'b0000;
  endfunction

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (!drained() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout waited=%0d cycles limit=2000", name, t);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int bad_tx, bad_rd, bad_busy;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx",   64'(tx),   64'hF);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_rd",   64'(rd),   64'h0);
    check("reset_done", 64'(done), 64'h0);
    rst = 1'b0;

    // Word waiting with enable low: line must stay idle for 100 cycles
    push(0, 8'hA5);
    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) bad_tx++;
      if (rd[0] !== 1'b0) bad_rd++;
      if (busy[0] !== 1'b0) bad_busy++;
    end
    check("idle_tx_cycles_low",    64'(bad_tx),   64'd0);
    check("idle_rd_en_cycles",     64'(bad_rd),   64'd0);
    check("idle_busy_cycles_high", 64'(bad_busy), 64'd0);

    // 0xA5 in 8N1: start one cycle after enable rises
    n = cyc;
    expect_frame(0, 8'hA5, 1'b0, n + 1);
    en[0] = 1'b1;
    @(negedge clk);
    check("en_latency_tx", 64'(tx[0]), 64'd0);
    wait_drain("frame_a5");

    // Back-to-back 0x00 then 0xFF: second start exactly 40 cycles after the first
    en[0] = 1'b0;
    push(0, 8'h00);
    push(0, 8'hFF);
    repeat (2) @(negedge clk);
    n = cyc;
    expect_frame(0, 8'h00, 1'b0, n + 1);
    expect_frame(0, 8'hFF, 1'b0, n + 41);
    en[0] = 1'b1;
    wait_drain("back_to_back");

    // Even parity 0x07 -> 1, odd parity 0x07 -> 0; 8N2 0x3C then 0x81, 44-cycle frames
    push(1, 8'h07);
    push(2, 8'h07);
    push(3, 8'h3C);
    push(3, 8'h81);
    repeat (2) @(negedge clk);
    n = cyc;
    expect_frame(1, 8'h07, 1'b1, n + 1);
    expect_frame(2, 8'h07, 1'b0, n + 1);
    expect_frame(3, 8'h3C, 1'b0, n + 1);
    expect_frame(3, 8'h81, 1'b0, n + 45);
    en[3:1] = 3'b111;
    wait_drain("parity_and_two_stop");

    // Reset during data bit 3 of 0xA5: line high at once, fresh frame after release
    en[0] = 1'b0;
    push(0, 8'hA5);
    repeat (2) @(negedge clk);
    n = cyc;
    en[0] = 1'b1;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    push(0, 8'h5A);
    #1;
    check("midframe_rst_tx",   64'(tx[0]),   64'd1);
    check("midframe_rst_busy", 64'(busy[0]), 64'd0);
    check("midframe_rst_rd",   64'(rd[0]),   64'd0);
    repeat (3) @(negedge clk);
    n = cyc;
    expect_frame(0, 8'h5A, 1'b0, n + 1);
    rst = 1'b0;
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
